uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART transmitter between two packet sources: s0 (image pixel bytes from the
//  image sender path) and s1 (status/ack messages). Each source gets a whole packet at a time.
//  Every packet is framed as SYNC, CHAN_ID, LEN_HI, LEN_LO, payload, CSUM.
//  Sits between the image/message producers and the UART tx core, so the host can demultiplex the streams.
// PARAMETERS
//  STARVE_LIMIT  4      consecutive s1 grants allowed while s0 waits; the next grant then goes to s0
//  SYNC_BYTE     8'hA5  first byte of every packet
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  s0_req      in   1   s0 requests a packet (level; held until s0_grant)
//  s0_len      in   16  s0 payload byte count, sampled on grant cycle
//  s0_data     in   8   s0 payload byte
//  s0_valid    in   1   s0_data valid
//  s0_ready    out  1   payload byte accepted when s0_valid & s0_ready
//  s0_grant    out  1   high from grant until packet end
//  s1_req/s1_len/s1_data/s1_valid/s1_ready/s1_grant  -- identical set for s1
//  tx_data     out  8   byte to UART
//  txEn        out  1   UART enable, pulses with txStart
//  txStart     out  1   one-cycle start pulse
//  txBusy      in   1   UART busy
//  txDone      in   1   one-cycle pulse, byte finished
//  pkt_done    out  1   one-cycle pulse after the CSUM txDone
//  state       out  3   current phase (debug)
// BEHAVIOUR
//  Reset: all outputs 0, phase=IDLE, starve counter=0; tx_data=0. Reset mid-packet abandons the packet.
//  Phases: IDLE(0) SYNC(1) CHAN(2) LENH(3) LENL(4) DATA(5) CSUM(6). 7 is illegal -> IDLE.
//  Each non-IDLE phase has sub-steps ISSUE -> WAIT.
//   - ISSUE: when txBusy=0, register tx_data and pulse txStart=txEn=1 for exactly 1 cycle; go to WAIT.
//   - WAIT: hold until txDone; then move to the next phase in ISSUE.
//   - txDone outside WAIT is ignored.
//  IDLE arbitration (sampled each cycle):
//   - only one req -> grant it.
//   - both req -> s1 wins unless starve counter==STARVE_LIMIT, then s0 wins.
//   - counter: +1 on an s1 grant while s0_req=1; cleared on an s0 grant; saturates.
//   - On grant: latch len and channel id; grant line high next cycle; go to SYNC.
//  Grant is held through CSUM regardless of req deassertion; req is not re-sampled until IDLE.
//  CHAN byte: s0 -> 8'h01, s1 -> 8'h02. LENH/LENL: latched len[15:8] / len[7:0].
//  DATA:
//   - sx_ready = granted & phase==DATA & sub==ISSUE & ~txBusy & remaining!=0.
//   - On valid&ready: tx_data<=data and txStart pulses next cycle (1-cycle latency); remaining--.
//   - Source stalls (valid=0) just hold ISSUE, with no timeout.
//   - After the txDone of the last byte -> CSUM.
//   - len==0: skip DATA, LENL -> CSUM.
//  CSUM = XOR of CHAN, LENH, LENL and all payload bytes (SYNC excluded); running 8b reg cleared at grant.
//  After CSUM txDone: pkt_done=1 for 1 cycle, grant drops the same cycle, -> IDLE.
//   - Earliest next grant is the following cycle.
//  At most one grant is high; sx_ready never high for the non-granted source.
//  Throughput bounded by UART: one byte per txStart..txDone interval plus 1 issue cycle.
// STRUCTURE
//  Shared include uart_pkt_defs.vh:
//   - SYNC_BYTE default, CHAN_IMG=8'h01, CHAN_MSG=8'h02.
//   - Phase encodings, so host-side decode and the RX parser share them.
//  One sub-module uart_byte_issuer:
//   - Owns the ISSUE/WAIT handshake (byte_in, byte_valid, byte_ready, tx_data, txStart, txEn, txBusy, txDone).
//   - Top holds the arbiter, phase FSM, counters and checksum.
// TESTING
//  UART model: txBusy high 10 cycles after txStart, then txDone pulse.
//  1. s0_req, len=3, data 11,22,33 -> tx bytes A5,01,00,03,11,22,33,CSUM=01^00^03^11^22^33=02;
//     one pkt_done.
//  2. s1_req len=0 -> A5,02,00,00,02; s1_ready never asserted.
//  3. s0 and s1 both req continuously, STARVE_LIMIT=4 -> grant order s1,s1,s1,s1,s0,s1,...
//  4. s0 valid low 50 cycles mid-payload -> no txStart during stall; stream resumes intact.
//  5. rst pulsed during DATA byte 2 of len=5 -> next cycle all outputs 0, phase IDLE;
//     the next req starts a fresh A5 frame.
//  6. s1_req dropped after grant, len=2 -> packet still completes; spurious txDone in IDLE ignored.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared framing constants and phase encodings for the UART packet scheduler and host-side decode.
// No logic; imported by the scheduler top and the byte issuer.
package uart_tx_scheduler_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CHAN_IMG      = 8'h01;
    localparam logic [7:0] CHAN_MSG      = 8'h02;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SYNC = 3'd1,
        PH_CHAN = 3'd2,
        PH_LENH = 3'd3,
        PH_LENL = 3'd4,
        PH_DATA = 3'd5,
        PH_CSUM = 3'd6
    } phase_t;

    typedef enum logic {
        SUB_ISSUE = 1'b0,
        SUB_WAIT  = 1'b1
    } sub_t;

    // Phases whose bytes are folded into the trailing checksum (SYNC is not).
    function automatic logic in_csum(input phase_t p);
        return (p == PH_CHAN) || (p == PH_LENH) || (p == PH_LENL) || (p == PH_DATA);
    endfunction

endpackage

// File: rtl/uart_byte_issuer.sv
// ISSUE/WAIT handshake to the UART core: accepts one byte when idle, pulses txStart/txEn the next cycle.
// Latency 1 cycle byte-to-start; byte_ready stays low while the UART is busy or a byte is in flight.
module uart_byte_issuer
    import uart_tx_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       byte_done,
    output logic [7:0] tx_data,
    output logic       txStart,
    output logic       txEn,
    input  logic       txBusy,
    input  logic       txDone
);

    sub_t sub_q;
    sub_t sub_d;
    logic accept;

    assign byte_ready = (sub_q == SUB_ISSUE) && !txBusy;
    assign accept     = byte_valid && byte_ready;
    // txDone only counts while a byte of ours is outstanding.
    assign byte_done  = (sub_q == SUB_WAIT) && txDone;
    assign txEn       = txStart;

    always_comb begin
        sub_d = sub_q;
        case (sub_q)
            SUB_ISSUE: if (accept)    sub_d = SUB_WAIT;
            SUB_WAIT:  if (byte_done) sub_d = SUB_ISSUE;
            default:                  sub_d = SUB_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q   <= SUB_ISSUE;
            tx_data <= 8'h00;
            txStart <= 1'b0;
        end else begin
            sub_q   <= sub_d;
            txStart <= accept;
            if (accept) begin
                tx_data <= byte_in;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two packet sources onto one UART, framing SYNC,CHAN,LENH,LENL,payload,CSUM per packet.
// Grant 1 cycle after request; payload ready only in DATA when the UART is idle; stalls never time out.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_req,
    input  logic [15:0] s0_len,
    input  logic [7:0]  s0_data,
    input  logic        s0_valid,
    output logic        s0_ready,
    output logic        s0_grant,
    input  logic        s1_req,
    input  logic [15:0] s1_len,
    input  logic [7:0]  s1_data,
    input  logic        s1_valid,
    output logic        s1_ready,
    output logic        s1_grant,
    output logic [7:0]  tx_data,
    output logic        txEn,
    output logic        txStart,
    input  logic        txBusy,
    input  logic        txDone,
    output logic        pkt_done,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    phase_t            phase_q;
    phase_t            phase_d;
    logic              grant0_q;
    logic              grant1_q;
    logic              sel_q;
    logic [15:0]       len_q;
    logic [15:0]       remaining_q;
    logic [7:0]        csum_q;
    logic [CNT_W-1:0]  starve_q;
    logic              pkt_done_q;

    logic              pick0;
    logic              pick1;
    logic              src_valid;
    logic [7:0]        src_data;
    logic              data_left;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_done;
    logic              accept;

    assign pick0     = s0_req && (!s1_req || (starve_q == LIMIT));
    assign pick1     = s1_req && !pick0;
    assign src_valid = sel_q ? s1_valid : s0_valid;
    assign src_data  = sel_q ? s1_data : s0_data;
    assign data_left = (phase_q == PH_DATA) && (remaining_q != 16'd0);
    assign accept    = byte_valid && byte_ready;

    assign s0_ready  = grant0_q && data_left && byte_ready;
    assign s1_ready  = grant1_q && data_left && byte_ready;
    assign s0_grant  = grant0_q;
    assign s1_grant  = grant1_q;
    assign pkt_done  = pkt_done_q;
    assign state     = phase_q;

    always_comb begin
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        case (phase_q)
            PH_SYNC: begin byte_in = SYNC_BYTE;                    byte_valid = 1'b1; end
            PH_CHAN: begin byte_in = sel_q ? CHAN_MSG : CHAN_IMG;  byte_valid = 1'b1; end
            PH_LENH: begin byte_in = len_q[15:8];                  byte_valid = 1'b1; end
            PH_LENL: begin byte_in = len_q[7:0];                   byte_valid = 1'b1; end
            PH_DATA: begin byte_in = src_data;  byte_valid = src_valid && data_left; end
            PH_CSUM: begin byte_in = csum_q;                       byte_valid = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: if (s0_req || s1_req) phase_d = PH_SYNC;
            PH_SYNC: if (byte_done) phase_d = PH_CHAN;
            PH_CHAN: if (byte_done) phase_d = PH_LENH;
            PH_LENH: if (byte_done) phase_d = PH_LENL;
            PH_LENL: if (byte_done) phase_d = (len_q == 16'd0) ? PH_CSUM : PH_DATA;
            PH_DATA: if (byte_done && remaining_q == 16'd0) phase_d = PH_CSUM;
            PH_CSUM: if (byte_done) phase_d = PH_IDLE;
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            sel_q       <= 1'b0;
            len_q       <= 16'd0;
            remaining_q <= 16'd0;
            csum_q      <= 8'h00;
            starve_q    <= '0;
            pkt_done_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pkt_done_q <= 1'b0;
            if (phase_q == PH_IDLE) begin
                if (pick0) begin
                    grant0_q    <= 1'b1;
                    sel_q       <= 1'b0;
                    len_q       <= s0_len;
                    remaining_q <= s0_len;
                    csum_q      <= 8'h00;
                    starve_q    <= '0;
                end else if (pick1) begin
                    grant1_q    <= 1'b1;
                    sel_q       <= 1'b1;
                    len_q       <= s1_len;
                    remaining_q <= s1_len;
                    csum_q      <= 8'h00;
                    if (s0_req && starve_q != LIMIT) begin
                        starve_q <= starve_q + CNT_W'(1);
                    end
                end
            end
            if (accept && in_csum(phase_q)) begin
                csum_q <= csum_q ^ byte_in;
            end
            if (accept && phase_q == PH_DATA) begin
                remaining_q <= remaining_q - 16'd1;
            end
            // Leaving a packet phase for IDLE drops the grant in the same cycle pkt_done shows.
            if (phase_q != PH_IDLE && phase_d == PH_IDLE) begin
                grant0_q   <= 1'b0;
                grant1_q   <= 1'b0;
                pkt_done_q <= (phase_q == PH_CSUM);
            end
        end
    end

    uart_byte_issuer u_issuer (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx_data    (tx_data),
        .txStart    (txStart),
        .txEn       (txEn),
        .txBusy     (txBusy),
        .txDone     (txDone)
    );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Table-driven packet vectors plus hand sequences for stall, reset, spurious txDone and starvation.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic [15:0] s0_len = 16'd0, s1_len = 16'd0;
    logic [7:0]  s0_data = 8'h00, s1_data = 8'h00;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic        s0_ready, s1_ready, s0_grant, s1_grant;
    logic [7:0]  tx_data;
    logic        txEn, txStart, pkt_done;
    logic        txBusy = 1'b0, txDone = 1'b0;
    logic [2:0]  state;

    uart_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_len(s0_len), .s0_data(s0_data), .s0_valid(s0_valid),
        .s0_ready(s0_ready), .s0_grant(s0_grant),
        .s1_req(s1_req), .s1_len(s1_len), .s1_data(s1_data), .s1_valid(s1_valid),
        .s1_ready(s1_ready), .s1_grant(s1_grant),
        .tx_data(tx_data), .txEn(txEn), .txStart(txStart),
        .txBusy(txBusy), .txDone(txDone), .pkt_done(pkt_done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        src;
        logic [15:0] len;
        logic [63:0] data;      // byte i at data[8*i +: 8]
        logic [7:0]  stall_at;  // 8'hFF: no stall
        logic [7:0]  csum;
    } vec_t;

    int errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    int grant_log[$];
    int start_cnt = 0, pd_cnt = 0, acc0 = 0, acc1 = 0, rdy0 = 0, rdy1 = 0, viol = 0;
    int bcnt = 0;
    bit spur = 1'b0;
    logic g0p = 1'b0, g1p = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // UART model: busy for 10 cycles after txStart, then a one-cycle txDone.
    always @(negedge clk) begin
        txDone = 1'b0;
        if (txStart === 1'b1) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_byte: got %0h, expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
            txBusy = 1'b1;
            bcnt = 10;
        end else if (txBusy) begin
            bcnt--;
            if (bcnt == 0) begin
                txBusy = 1'b0;
                txDone = 1'b1;
            end
        end else if (spur) begin
            txDone = 1'b1;
            spur = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (pkt_done === 1'b1) pd_cnt++;
        if (s0_valid && s0_ready === 1'b1) acc0++;
        if (s1_valid && s1_ready === 1'b1) acc1++;
        if (s0_ready === 1'b1) rdy0++;
        if (s1_ready === 1'b1) rdy1++;
        if (s0_grant === 1'b1 && s1_grant === 1'b1) viol++;
        if (s0_ready === 1'b1 && s0_grant !== 1'b1) viol++;
        if (s1_ready === 1'b1 && s1_grant !== 1'b1) viol++;
        if (pkt_done === 1'b1 && (s0_grant === 1'b1 || s1_grant === 1'b1)) viol++;
        if (txEn !== txStart) viol++;
        if (s0_grant === 1'b1 && !g0p) grant_log.push_back(0);
        if (s1_grant === 1'b1 && !g1p) grant_log.push_back(1);
        g0p = (s0_grant === 1'b1);
        g1p = (s1_grant === 1'b1);
    end

    task automatic set_req(input logic src, input logic req, input logic [15:0] len);
        if (src) begin s1_req = req; s1_len = len; end
        else     begin s0_req = req; s0_len = len; end
    endtask

    task automatic set_valid(input logic src, input logic v, input logic [7:0] d);
        if (src) begin s1_valid = v; s1_data = d; end
        else     begin s0_valid = v; s0_data = d; end
    endtask

    task automatic wait_grant(input logic src, output bit ok);
        int g = 0;
        while (!((src ? s1_grant : s0_grant) === 1'b1) && g < 200) begin tick(); g++; end
        ok = (g < 200);
        if (!ok) timeout("grant_wait");
    endtask

    task automatic send_payload(input logic src, input logic [63:0] d, input int n, input int stall_at);
        int guard;
        int sc;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                set_valid(src, 1'b0, 8'h00);
                sc = start_cnt;
                repeat (50) tick();
                check("stall_no_start", start_cnt, sc);
            end
            set_valid(src, 1'b1, d[8*i +: 8]);
            guard = 0;
            while (!((src ? s1_ready : s0_ready) === 1'b1) && guard < 600) begin tick(); guard++; end
            if (guard >= 600) begin
                timeout("payload_accept");
                set_valid(src, 1'b0, 8'h00);
                return;
            end
            tick();
        end
        set_valid(src, 1'b0, 8'h00);
    endtask

    task automatic run_pkt(input vec_t v);
        int pd0, a0, r0, g;
        bit ok;
        pd0 = pd_cnt;
        a0  = v.src ? acc1 : acc0;
        r0  = v.src ? rdy1 : rdy0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(v.src ? 8'h02 : 8'h01);
        exp_q.push_back(v.len[15:8]);
        exp_q.push_back(v.len[7:0]);
        for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.data[8*i +: 8]);
        exp_q.push_back(v.csum);
        set_req(v.src, 1'b1, v.len);
        wait_grant(v.src, ok);
        set_req(v.src, 1'b0, 16'h0000);
        if (!ok) return;
        send_payload(v.src, v.data, int'(v.len), (v.stall_at == 8'hFF) ? -1 : int'(v.stall_at));
        g = 0;
        while (pd_cnt == pd0 && g < 1000) begin tick(); g++; end
        if (g >= 1000) timeout("pkt_done_wait");
        repeat (3) tick();
        check("pkt_done_count", pd_cnt - pd0, 1);
        check("payload_accepts", (v.src ? acc1 : acc0) - a0, {16'h0, v.len});
        if (v.len == 16'd0) check("ready_never_len0", (v.src ? rdy1 : rdy0) - r0, 0);
        check("frame_complete", exp_q.size(), 0);
        check("idle_after_pkt", {29'h0, state}, 0);
        check("grants_dropped", {30'h0, s0_grant, s1_grant}, 0);
    endtask

    vec_t vecs [7];
    int   order [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        int g;
        int sc;
        int pd0;
        bit ok;
        vec_t fresh;

        vecs[0] = '{1'b0, 16'd3, 64'h0000_0000_0033_2211, 8'hFF, 8'h02};
        vecs[1] = '{1'b1, 16'd0, 64'h0,                   8'hFF, 8'h02};
        vecs[2] = '{1'b1, 16'd2, 64'h0000_0000_0000_A55A, 8'hFF, 8'hFF};
        vecs[3] = '{1'b0, 16'd4, 64'h0000_0000_0804_0201, 8'hFF, 8'h0A};
        vecs[4] = '{1'b0, 16'd4, 64'h0000_0000_4030_2010, 8'd2,  8'h45};
        vecs[5] = '{1'b1, 16'd8, 64'h8877_6655_4433_2211, 8'hFF, 8'h82};
        vecs[6] = '{1'b0, 16'd1, 64'h0000_0000_0000_00FF, 8'hFF, 8'hFF};
        fresh   = '{1'b1, 16'd1, 64'h0000_0000_0000_0077, 8'hFF, 8'h74};

        repeat (3) tick();
        check("reset_outputs", {14'h0, tx_data, txStart, txEn, s0_ready, s1_ready,
                                s0_grant, s1_grant, pkt_done, state}, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_pkt(vecs[k]);

        // Spurious txDone while idle must not start anything.
        sc = start_cnt;
        spur = 1'b1;
        repeat (6) tick();
        check("spurious_done_no_start", start_cnt, sc);
        check("spurious_done_idle", {29'h0, state}, 0);

        // Reset during the second payload byte of a 5-byte packet.
        pd0 = pd_cnt;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        exp_q.push_back(8'h05); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        set_req(1'b0, 1'b1, 16'd5);
        wait_grant(1'b0, ok);
        set_req(1'b0, 1'b0, 16'd0);
        if (ok) send_payload(1'b0, 64'h0000_0005_0403_0201, 2, -1);
        tick();
        rst = 1'b1;
        tick();
        check("reset_mid_packet", {14'h0, tx_data, txStart, txEn, s0_ready, s1_ready,
                                   s0_grant, s1_grant, pkt_done, state}, 0);
        rst = 1'b0;
        check("reset_partial_frame", exp_q.size(), 0);
        check("reset_no_pkt_done", pd_cnt - pd0, 0);
        run_pkt(fresh);

        // Both sources requesting continuously: starvation limit forces every fifth grant to s0.
        pd0 = pd_cnt;
        grant_log.delete();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(order[k] == 1 ? 8'h02 : 8'h01);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(order[k] == 1 ? 8'h02 : 8'h01);
        end
        s0_len = 16'd0; s1_len = 16'd0;
        s0_req = 1'b1;  s1_req = 1'b1;
        g = 0;
        while (grant_log.size() < 6 && g < 3000) begin tick(); g++; end
        s0_req = 1'b0; s1_req = 1'b0;
        if (g >= 3000) timeout("arb_grants");
        g = 0;
        while (pd_cnt - pd0 < 6 && g < 500) begin tick(); g++; end
        if (g >= 500) timeout("arb_pkt_done");
        repeat (3) tick();
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check("grant_order", grant_log[k], order[k]);
            else timeout("grant_order");
        end
        check("arb_pkt_count", pd_cnt - pd0, 6);
        check("arb_frames_complete", exp_q.size(), 0);

        check("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
